dds_ctrl_slave: RTL and testbench
=================================

# dds_ctrl_slave

Parametrised bus-slave register bank for the multi-channel DDS generator. It accepts the in-house AXI-style master protocol and holds per-channel waveform-store, frequency and phase settings in shadow registers. A commit register copies shadows to the active DDS controls for any set of channels on the same clock edge, so multi-channel phase-aligned retunes become possible. It also forwards wave-RAM writes to each DDS core and reports SLVERR on any access outside the map.

## Interface
- CHANNEL_NUM, 2, number of DDS channels (1..15)
- WAVE_STORE, 2, log2 of wave stores per channel (S = 2**WAVE_STORE, 1..6)
- FREQ_W, 32, frequency control word width (<=32)
- PHASE_W, 12, phase control word width (<=32)
- OFFSET_ADDR, 32'h4000_0000, bus base address; word address A = ADDR - OFFSET_ADDR

Ports:
- clk  in  1  clock
- DDS_SLAVE_RSTN_SYNC  in  1  reset, asynchronous, active-low
- DDS_SLAVE_WR_ADDR_{ID,,LEN,BURST,VALID}  in  4/32/8/2/1  write-address channel; WR_ADDR_READY out 1
- DDS_SLAVE_WR_{DATA,STRB,DATA_LAST,DATA_VALID}  in  32/4/1/1  write-data channel; STRB is ignored; WR_DATA_READY out 1
- DDS_SLAVE_WR_BACK_{ID,RESP,VALID}  out  4/2/1  write response; WR_BACK_READY in 1
- DDS_SLAVE_RD_ADDR_{ID,,LEN,BURST,VALID}  in  4/32/8/2/1  read-address channel; RD_ADDR_READY out 1
- DDS_SLAVE_RD_{BACK_ID,DATA,DATA_RESP,DATA_LAST,DATA_VALID}  out  4/32/2/1/1  read-data channel; RD_DATA_READY in 1
- wave_sel_o  out  CHANNEL_NUM*WAVE_STORE  active store select per channel
- freq_ctrl_o  out  CHANNEL_NUM*S*FREQ_W  active frequency words, channel-major then store
- phase_ctrl_o  out  CHANNEL_NUM*S*PHASE_W  active phase words, same packing
- commit_o  out  CHANNEL_NUM  one-cycle pulse per channel when its active set is updated
- dds_wr_enable_o  out  CHANNEL_NUM  wave-RAM write enable per channel
- dds_wr_valid_o  out  CHANNEL_NUM  wave-RAM write strobe
- dds_wr_data_o  out  32  equals DDS_SLAVE_WR_DATA

## Operation
- Address decoding: ch = A[11:8], reg = A[7:0].
- Per-channel registers, valid for ch < CHANNEL_NUM:
  - 0x00 wave_sel, R/W shadow
  - 0x01 wr_enable, R/W, bit0, takes effect immediately (not shadowed)
  - 0x02 data, write-only
  - 0x03 status, read-only, bit0 = pending
  - 0x40+s freq[s], R/W shadow
  - 0x80+s phase[s], R/W shadow, for s < S
- Global registers (ch = 0xF):
  - 0xF00 commit, write-only; bit c set commits channel c
  - 0xF01 info, read-only = {16'd0, 4'(CHANNEL_NUM), 4'(WAVE_STORE), 8'h02}
- Any other A, or A[31:12] != 0, is invalid.
- Shadow writes keep the low FREQ_W, PHASE_W or WAVE_STORE bits. Reads zero-extend. Reads return the shadow value, never the active value.
- pending[c]:
  - set by any shadow write to channel c
  - cleared by a commit of c
  - when both occur in one cycle, the commit copies the old shadow and pending ends set
- Commit bits >= CHANNEL_NUM are ignored, without error.
- Data write to 0x02: dds_wr_valid_o[ch] = wr_enable[ch] for that beat, otherwise 0.
- Write FSM:
  - IDLE -> DATA on address handshake
  - DATA -> RESP on handshake of the last beat
  - RESP -> IDLE on the response handshake
- Read FSM:
  - IDLE -> DATA on address handshake
  - DATA -> IDLE on handshake of the last beat
- Bursts:
  - BURST 2'b00 (FIXED) holds A for every beat
  - BURST 2'b01 (INCR) adds 1 per accepted beat
  - 2'b10 and 2'b11 are errors; their beats are accepted and discarded
- Write errors:
  - An invalid or read-only target drops that beat.
  - The error flag is sticky for the whole burst, so WR_BACK_RESP = 2'b10, otherwise 2'b00.
- Read errors:
  - An invalid or write-only target returns RD_DATA = 32'hFFFF_FFFF with RD_DATA_RESP = 2'b10 for that beat.
  - The error is sticky for later beats of the burst.
- Beat counter: RD_DATA_LAST = (beats == LEN). The counter clears in IDLE.
- Read and write FSMs run independently. A same-cycle write and read of one register returns the pre-write value.

## Timing
- Reset values:
  - FSMs to IDLE
  - all shadow, active and pending registers 0
  - wr_enable 0
  - WR_ADDR_READY = RD_ADDR_READY = 1
  - WR_DATA_READY, WR_BACK_VALID, RD_DATA_VALID, RD_DATA_LAST, commit_o, dds_wr_valid_o all 0
  - BACK_ID 0, RESP 0, RD_DATA 0
- Reset asserted mid-burst aborts the burst immediately with no response. Registers return to reset values.
- WR_ADDR_READY = (wr FSM == IDLE).
- WR_DATA_READY = 1 throughout DATA, so one beat per cycle.
- WR_BACK_VALID rises the cycle after the last-beat handshake.
- RD_DATA_VALID = 1 throughout read DATA, starting the cycle after the address handshake. RD_DATA and RESP are combinational from the current address.
- Register writes are visible on the edge that ends the beat's handshake cycle.
- Commit beat at cycle N: active outputs and commit_o change at N+1; commit_o is high for exactly one cycle.
- dds_wr_valid_o and dds_wr_data_o are combinational and valid in the handshake cycle.

## Test plan
- Shadow isolation then commit:
  - Write freq[1] of ch0 = 0x0123_4567.
  - Required: freq_ctrl_o unchanged and status0 reads 1.
  - Write 0xF00 = 0x1.
  - Required: freq_ctrl_o ch0/store1 = 0x0123_4567 one cycle later, commit_o = 2'b01 for one cycle, status0 reads 0.
- Aligned commit: write phase[0] = 0x800 on ch0 and ch1, then commit 0x3. Required: both active phases update on the same edge and commit_o = 2'b11.
- INCR write burst: LEN = 3 at A = 0x040. Required: freq[0..3] of ch0 = data beats, BACK_RESP = 0, BACK_ID echoes the address ID.
- Error paths:
  - Write to A = 0x2F0. Required: RESP 2'b10 and no register change.
  - WRAP burst. Required: RESP 2'b10.
  - Read burst LEN = 1 at A = 0x002. Required: two beats, each 0xFFFF_FFFF with RESP 2'b10, LAST on beat 2.
- Wave data:
  - Set wr_enable ch1 = 1, then FIXED burst of 4 beats to 0x102. Required: dds_wr_valid_o = 2'b10 on each of the 4 beats.
  - Required: with wr_enable ch1 = 0, no strobes.
- Reset mid-burst: assert reset during beat 2 of an 8-beat write. Required: all outputs return to reset values, ADDR_READY = 1 after release, and a new burst completes normally.

Source files
------------

// File: rtl/dds_ctrl_slave.sv
// Bus-slave register bank for the multi-channel DDS: per-channel shadow settings,
// a multi-channel commit that copies shadows to the active controls, and wave-RAM write forwarding.
module dds_ctrl_slave #(
    parameter int          CHANNEL_NUM = 2,
    parameter int          WAVE_STORE  = 2,
    parameter int          FREQ_W      = 32,
    parameter int          PHASE_W     = 12,
    parameter logic [31:0] OFFSET_ADDR = 32'h4000_0000
) (
    input  logic                                        clk,
    input  logic                                        DDS_SLAVE_RSTN_SYNC,
    input  logic [3:0]                                  DDS_SLAVE_WR_ADDR_ID,
    input  logic [31:0]                                 DDS_SLAVE_WR_ADDR,
    input  logic [7:0]                                  DDS_SLAVE_WR_ADDR_LEN,
    input  logic [1:0]                                  DDS_SLAVE_WR_ADDR_BURST,
    input  logic                                        DDS_SLAVE_WR_ADDR_VALID,
    output logic                                        DDS_SLAVE_WR_ADDR_READY,
    input  logic [31:0]                                 DDS_SLAVE_WR_DATA,
    input  logic [3:0]                                  DDS_SLAVE_WR_STRB,
    input  logic                                        DDS_SLAVE_WR_DATA_LAST,
    input  logic                                        DDS_SLAVE_WR_DATA_VALID,
    output logic                                        DDS_SLAVE_WR_DATA_READY,
    output logic [3:0]                                  DDS_SLAVE_WR_BACK_ID,
    output logic [1:0]                                  DDS_SLAVE_WR_BACK_RESP,
    output logic                                        DDS_SLAVE_WR_BACK_VALID,
    input  logic                                        DDS_SLAVE_WR_BACK_READY,
    input  logic [3:0]                                  DDS_SLAVE_RD_ADDR_ID,
    input  logic [31:0]                                 DDS_SLAVE_RD_ADDR,
    input  logic [7:0]                                  DDS_SLAVE_RD_ADDR_LEN,
    input  logic [1:0]                                  DDS_SLAVE_RD_ADDR_BURST,
    input  logic                                        DDS_SLAVE_RD_ADDR_VALID,
    output logic                                        DDS_SLAVE_RD_ADDR_READY,
    output logic [3:0]                                  DDS_SLAVE_RD_BACK_ID,
    output logic [31:0]                                 DDS_SLAVE_RD_DATA,
    output logic [1:0]                                  DDS_SLAVE_RD_DATA_RESP,
    output logic                                        DDS_SLAVE_RD_DATA_LAST,
    output logic                                        DDS_SLAVE_RD_DATA_VALID,
    input  logic                                        DDS_SLAVE_RD_DATA_READY,
    output logic [CHANNEL_NUM*WAVE_STORE-1:0]           wave_sel_o,
    output logic [CHANNEL_NUM*(2**WAVE_STORE)*FREQ_W-1:0]  freq_ctrl_o,
    output logic [CHANNEL_NUM*(2**WAVE_STORE)*PHASE_W-1:0] phase_ctrl_o,
    output logic [CHANNEL_NUM-1:0]                      commit_o,
    output logic [CHANNEL_NUM-1:0]                      dds_wr_enable_o,
    output logic [CHANNEL_NUM-1:0]                      dds_wr_valid_o,
    output logic [31:0]                                 dds_wr_data_o
);

    localparam int S = 2 ** WAVE_STORE;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    typedef struct packed {
        logic       rd_ok;
        logic       wr_ok;
        logic       is_wave;
        logic       is_wren;
        logic       is_data;
        logic       is_status;
        logic       is_freq;
        logic       is_phase;
        logic       is_commit;
        logic       is_info;
        logic [3:0] ch;
        logic [5:0] s;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] a);
        dec_t       d;
        logic       hi_ok;
        logic       ch_ok;
        logic       s_ok;
        logic [7:0] r;
        d           = '0;
        r           = a[7:0];
        d.ch        = a[11:8];
        d.s         = a[5:0];
        hi_ok       = (a[31:12] == 20'd0);
        ch_ok       = hi_ok && (a[11:8] < 4'(CHANNEL_NUM));
        s_ok        = ({1'b0, a[5:0]} < 7'(S));
        d.is_wave   = ch_ok && (r == 8'h00);
        d.is_wren   = ch_ok && (r == 8'h01);
        d.is_data   = ch_ok && (r == 8'h02);
        d.is_status = ch_ok && (r == 8'h03);
        d.is_freq   = ch_ok && (r[7:6] == 2'b01) && s_ok;
        d.is_phase  = ch_ok && (r[7:6] == 2'b10) && s_ok;
        d.is_commit = hi_ok && (a[11:8] == 4'hF) && (r == 8'h00);
        d.is_info   = hi_ok && (a[11:8] == 4'hF) && (r == 8'h01);
        d.wr_ok     = d.is_wave | d.is_wren | d.is_data | d.is_freq | d.is_phase | d.is_commit;
        d.rd_ok     = d.is_wave | d.is_wren | d.is_status | d.is_freq | d.is_phase | d.is_info;
        return d;
    endfunction

    wr_state_t wr_state_reg, wr_state_next;
    rd_state_t rd_state_reg, rd_state_next;

    logic [31:0] wr_addr_reg;
    logic [3:0]  wr_id_reg;
    logic [1:0]  wr_burst_reg;
    logic        wr_err_reg;
    logic [31:0] rd_addr_reg;
    logic [3:0]  rd_id_reg;
    logic [7:0]  rd_len_reg;
    logic [7:0]  rd_beats_reg;
    logic [1:0]  rd_burst_reg;
    logic        rd_err_reg;

    logic [WAVE_STORE-1:0] wave_sh_reg  [CHANNEL_NUM];
    logic [WAVE_STORE-1:0] wave_act_reg [CHANNEL_NUM];
    logic [FREQ_W-1:0]     freq_sh_reg  [CHANNEL_NUM][S];
    logic [FREQ_W-1:0]     freq_act_reg [CHANNEL_NUM][S];
    logic [PHASE_W-1:0]    phase_sh_reg [CHANNEL_NUM][S];
    logic [PHASE_W-1:0]    phase_act_reg[CHANNEL_NUM][S];
    logic [CHANNEL_NUM-1:0] pending_reg;
    logic [CHANNEL_NUM-1:0] wr_enable_reg;
    logic [CHANNEL_NUM-1:0] commit_reg;

    dec_t wd;
    dec_t rdd;
    logic wr_beat, wr_do, wr_beat_err, wr_burst_bad;
    logic rd_beat, rd_last, rd_beat_bad;
    logic [CHANNEL_NUM-1:0] commit_mask;
    logic [CHANNEL_NUM-1:0] shadow_wr;
    logic [31:0] rd_word;

    wire unused_inputs = ^{DDS_SLAVE_WR_STRB, DDS_SLAVE_WR_ADDR_LEN, wd.rd_ok, wd.is_status, wd.is_info,
                           rdd.wr_ok, rdd.is_data, rdd.is_commit, rd_burst_reg[1]};

    assign wd  = decode(wr_addr_reg);
    assign rdd = decode(rd_addr_reg);

    // WRAP/reserved bursts keep handshaking but never touch the bank
    assign wr_burst_bad = wr_burst_reg[1];
    assign wr_beat      = (wr_state_reg == W_DATA) && DDS_SLAVE_WR_DATA_VALID;
    assign wr_do        = wr_beat && !wr_burst_bad && wd.wr_ok;
    assign wr_beat_err  = wr_beat && (wr_burst_bad || !wd.wr_ok);
    assign commit_mask  = (wr_do && wd.is_commit) ? DDS_SLAVE_WR_DATA[CHANNEL_NUM-1:0] : '0;

    always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
        if (!DDS_SLAVE_RSTN_SYNC) begin
            wr_state_reg <= W_IDLE;
            rd_state_reg <= R_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE:  if (DDS_SLAVE_WR_ADDR_VALID) wr_state_next = W_DATA;
            W_DATA:  if (wr_beat && DDS_SLAVE_WR_DATA_LAST) wr_state_next = W_RESP;
            W_RESP:  if (DDS_SLAVE_WR_BACK_READY) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (DDS_SLAVE_RD_ADDR_VALID) rd_state_next = R_DATA;
            R_DATA:  if (rd_beat && rd_last) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
        if (!DDS_SLAVE_RSTN_SYNC) begin
            wr_addr_reg  <= '0;
            wr_id_reg    <= '0;
            wr_burst_reg <= '0;
            wr_err_reg   <= 1'b0;
        end else if (wr_state_reg == W_IDLE && DDS_SLAVE_WR_ADDR_VALID) begin
            wr_addr_reg  <= DDS_SLAVE_WR_ADDR - OFFSET_ADDR;
            wr_id_reg    <= DDS_SLAVE_WR_ADDR_ID;
            wr_burst_reg <= DDS_SLAVE_WR_ADDR_BURST;
            wr_err_reg   <= DDS_SLAVE_WR_ADDR_BURST[1];
        end else if (wr_beat) begin
            if (wr_beat_err) wr_err_reg <= 1'b1;
            if (wr_burst_reg == 2'b01) wr_addr_reg <= wr_addr_reg + 32'd1;
        end
    end

    assign rd_beat     = (rd_state_reg == R_DATA) && DDS_SLAVE_RD_DATA_READY;
    assign rd_last     = (rd_state_reg == R_DATA) && (rd_beats_reg == rd_len_reg);
    assign rd_beat_bad = rd_err_reg || !rdd.rd_ok;

    always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
        if (!DDS_SLAVE_RSTN_SYNC) begin
            rd_addr_reg  <= '0;
            rd_id_reg    <= '0;
            rd_len_reg   <= '0;
            rd_beats_reg <= '0;
            rd_burst_reg <= '0;
            rd_err_reg   <= 1'b0;
        end else if (rd_state_reg == R_IDLE && DDS_SLAVE_RD_ADDR_VALID) begin
            rd_addr_reg  <= DDS_SLAVE_RD_ADDR - OFFSET_ADDR;
            rd_id_reg    <= DDS_SLAVE_RD_ADDR_ID;
            rd_len_reg   <= DDS_SLAVE_RD_ADDR_LEN;
            rd_beats_reg <= '0;
            rd_burst_reg <= DDS_SLAVE_RD_ADDR_BURST;
            rd_err_reg   <= DDS_SLAVE_RD_ADDR_BURST[1];
        end else if (rd_beat) begin
            rd_beats_reg <= rd_last ? 8'd0 : rd_beats_reg + 8'd1;
            rd_err_reg   <= rd_beat_bad;
            if (rd_burst_reg == 2'b01) rd_addr_reg <= rd_addr_reg + 32'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_shadow_wr
            assign shadow_wr[gi] = wr_do && (wd.ch == 4'(gi)) && (wd.is_wave | wd.is_freq | wd.is_phase);
        end
    endgenerate

    always_ff @(posedge clk or negedge DDS_SLAVE_RSTN_SYNC) begin
        if (!DDS_SLAVE_RSTN_SYNC) begin
            pending_reg   <= '0;
            wr_enable_reg <= '0;
            commit_reg    <= '0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                wave_sh_reg[c]  <= '0;
                wave_act_reg[c] <= '0;
                for (int s = 0; s < S; s++) begin
                    freq_sh_reg[c][s]   <= '0;
                    freq_act_reg[c][s]  <= '0;
                    phase_sh_reg[c][s]  <= '0;
                    phase_act_reg[c][s] <= '0;
                end
            end
        end else begin
            commit_reg  <= commit_mask;
            // A same-edge shadow write wins the pending bit; the commit still copies the old shadow
            pending_reg <= shadow_wr | (pending_reg & ~commit_mask);
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                if (commit_mask[c]) begin
                    wave_act_reg[c] <= wave_sh_reg[c];
                    for (int s = 0; s < S; s++) begin
                        freq_act_reg[c][s]  <= freq_sh_reg[c][s];
                        phase_act_reg[c][s] <= phase_sh_reg[c][s];
                    end
                end
                if (wr_do && wd.ch == 4'(c)) begin
                    if (wd.is_wave) wave_sh_reg[c] <= DDS_SLAVE_WR_DATA[WAVE_STORE-1:0];
                    if (wd.is_wren) wr_enable_reg[c] <= DDS_SLAVE_WR_DATA[0];
                    for (int s = 0; s < S; s++) begin
                        if (wd.is_freq && wd.s == 6'(s)) freq_sh_reg[c][s] <= DDS_SLAVE_WR_DATA[FREQ_W-1:0];
                        if (wd.is_phase && wd.s == 6'(s)) phase_sh_reg[c][s] <= DDS_SLAVE_WR_DATA[PHASE_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            if (rdd.ch == 4'(c)) begin
                if (rdd.is_wave)   rd_word = 32'(wave_sh_reg[c]);
                if (rdd.is_wren)   rd_word = {31'd0, wr_enable_reg[c]};
                if (rdd.is_status) rd_word = {31'd0, pending_reg[c]};
                for (int s = 0; s < S; s++) begin
                    if (rdd.is_freq && rdd.s == 6'(s))  rd_word = 32'(freq_sh_reg[c][s]);
                    if (rdd.is_phase && rdd.s == 6'(s)) rd_word = 32'(phase_sh_reg[c][s]);
                end
            end
        end
        if (rdd.is_info) rd_word = {16'd0, 4'(CHANNEL_NUM), 4'(WAVE_STORE), 8'h02};
    end

    assign DDS_SLAVE_WR_ADDR_READY = (wr_state_reg == W_IDLE);
    assign DDS_SLAVE_WR_DATA_READY = (wr_state_reg == W_DATA);
    assign DDS_SLAVE_WR_BACK_VALID = (wr_state_reg == W_RESP);
    assign DDS_SLAVE_WR_BACK_RESP  = (wr_state_reg == W_RESP && wr_err_reg) ? 2'b10 : 2'b00;
    assign DDS_SLAVE_WR_BACK_ID    = wr_id_reg;

    assign DDS_SLAVE_RD_ADDR_READY = (rd_state_reg == R_IDLE);
    assign DDS_SLAVE_RD_DATA_VALID = (rd_state_reg == R_DATA);
    assign DDS_SLAVE_RD_DATA_LAST  = rd_last;
    assign DDS_SLAVE_RD_BACK_ID    = rd_id_reg;
    assign DDS_SLAVE_RD_DATA       = (rd_state_reg != R_DATA) ? 32'd0 :
                                     (rd_beat_bad ? 32'hFFFF_FFFF : rd_word);
    assign DDS_SLAVE_RD_DATA_RESP  = (rd_state_reg == R_DATA && rd_beat_bad) ? 2'b10 : 2'b00;

    assign commit_o        = commit_reg;
    assign dds_wr_enable_o = wr_enable_reg;
    assign dds_wr_data_o   = DDS_SLAVE_WR_DATA;

    generate
        for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_out
            assign wave_sel_o[gi*WAVE_STORE +: WAVE_STORE] = wave_act_reg[gi];
            assign dds_wr_valid_o[gi] = wr_do && wd.is_data && (wd.ch == 4'(gi)) && wr_enable_reg[gi];
            for (genvar gj = 0; gj < S; gj++) begin : g_store
                assign freq_ctrl_o[(gi*S+gj)*FREQ_W +: FREQ_W]    = freq_act_reg[gi][gj];
                assign phase_ctrl_o[(gi*S+gj)*PHASE_W +: PHASE_W] = phase_act_reg[gi][gj];
            end
        end
    endgenerate

endmodule

// File: tb/tb_dds_ctrl_slave.sv
// Directed bench for dds_ctrl_slave: a single-beat vector table plus hand-written
// burst, commit, wave-data and mid-burst reset sequences.
module tb_dds_ctrl_slave;
    localparam int          CH  = 2;
    localparam int          S   = 4;
    localparam int          FW  = 32;
    localparam int          PW  = 12;
    localparam logic [31:0] OFF = 32'h4000_0000;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [3:0]  wa_id = '0;
    logic [31:0] wa_addr = '0;
    logic [7:0]  wa_len = '0;
    logic [1:0]  wa_burst = '0;
    logic        wa_valid = 1'b0;
    logic        wa_ready;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = 4'hF;
    logic        w_last = 1'b0;
    logic        w_valid = 1'b0;
    logic        w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready = 1'b0;
    logic [3:0]  ra_id = '0;
    logic [31:0] ra_addr = '0;
    logic [7:0]  ra_len = '0;
    logic [1:0]  ra_burst = '0;
    logic        ra_valid = 1'b0;
    logic        ra_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [CH*2-1:0]    wave_sel_o;
    logic [CH*S*FW-1:0] freq_ctrl_o;
    logic [CH*S*PW-1:0] phase_ctrl_o;
    logic [CH-1:0] commit_o, dds_wr_enable_o, dds_wr_valid_o;
    logic [31:0]   dds_wr_data_o;

    dds_ctrl_slave dut (
        .clk(clk), .DDS_SLAVE_RSTN_SYNC(rstn),
        .DDS_SLAVE_WR_ADDR_ID(wa_id), .DDS_SLAVE_WR_ADDR(wa_addr), .DDS_SLAVE_WR_ADDR_LEN(wa_len),
        .DDS_SLAVE_WR_ADDR_BURST(wa_burst), .DDS_SLAVE_WR_ADDR_VALID(wa_valid), .DDS_SLAVE_WR_ADDR_READY(wa_ready),
        .DDS_SLAVE_WR_DATA(w_data), .DDS_SLAVE_WR_STRB(w_strb), .DDS_SLAVE_WR_DATA_LAST(w_last),
        .DDS_SLAVE_WR_DATA_VALID(w_valid), .DDS_SLAVE_WR_DATA_READY(w_ready),
        .DDS_SLAVE_WR_BACK_ID(b_id), .DDS_SLAVE_WR_BACK_RESP(b_resp), .DDS_SLAVE_WR_BACK_VALID(b_valid),
        .DDS_SLAVE_WR_BACK_READY(b_ready),
        .DDS_SLAVE_RD_ADDR_ID(ra_id), .DDS_SLAVE_RD_ADDR(ra_addr), .DDS_SLAVE_RD_ADDR_LEN(ra_len),
        .DDS_SLAVE_RD_ADDR_BURST(ra_burst), .DDS_SLAVE_RD_ADDR_VALID(ra_valid), .DDS_SLAVE_RD_ADDR_READY(ra_ready),
        .DDS_SLAVE_RD_BACK_ID(r_id), .DDS_SLAVE_RD_DATA(r_data), .DDS_SLAVE_RD_DATA_RESP(r_resp),
        .DDS_SLAVE_RD_DATA_LAST(r_last), .DDS_SLAVE_RD_DATA_VALID(r_valid), .DDS_SLAVE_RD_DATA_READY(r_ready),
        .wave_sel_o(wave_sel_o), .freq_ctrl_o(freq_ctrl_o), .phase_ctrl_o(phase_ctrl_o),
        .commit_o(commit_o), .dds_wr_enable_o(dds_wr_enable_o), .dds_wr_valid_o(dds_wr_valid_o),
        .dds_wr_data_o(dds_wr_data_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] wdata      [16];
    logic [1:0]  beat_strobe[16];
    logic [31:0] beat_wdata [16];
    logic [1:0]  beat_commit[16];
    logic [31:0] rdata      [16];
    logic [1:0]  rresp      [16];
    logic        rlast      [16];
    int          rbeats;
    logic [3:0]  rid;
    logic [1:0]  resp;
    logic [3:0]  bid;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic [1:0]  resp;
    } vec_t;
    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] freq_at(input int c, input int s);
        return freq_ctrl_o[(c*S+s)*FW +: FW];
    endfunction

    function automatic logic [31:0] phase_at(input int c, input int s);
        return 32'(phase_ctrl_o[(c*S+s)*PW +: PW]);
    endfunction

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, output logic [1:0] rsp, output logic [3:0] bi);
        int n;
        @(negedge clk);
        wa_id = id; wa_addr = OFF + a; wa_len = len; wa_burst = burst; wa_valid = 1'b1;
        n = 0;
        while (!wa_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        wa_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            w_data = wdata[i]; w_last = (i == int'(len)); w_valid = 1'b1;
            #1;
            beat_strobe[i] = dds_wr_valid_o;
            beat_wdata[i]  = dds_wr_data_o;
            check("wdata_ready", 32'(w_ready), 32'd1);
            @(negedge clk);
            beat_commit[i] = commit_o;
        end
        w_valid = 1'b0; w_last = 1'b0;
        n = 0;
        while (!b_valid && n < 20) begin @(negedge clk); n++; end
        check("bvalid_seen", 32'(b_valid), 32'd1);
        rsp = b_resp; bi = b_id;
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        $display("wr id=%0d A=%h len=%0d burst=%0d resp=%0d", id, a, len, burst, rsp);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst);
        int  n;
        logic l;
        @(negedge clk);
        ra_id = id; ra_addr = OFF + a; ra_len = len; ra_burst = burst; ra_valid = 1'b1;
        n = 0;
        while (!ra_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        ra_valid = 1'b0; r_ready = 1'b1;
        rbeats = 0;
        for (int i = 0; i < 16; i++) begin
            if (!r_valid) break;
            rdata[i] = r_data; rresp[i] = r_resp; rlast[i] = r_last; rid = r_id;
            l = r_last;
            rbeats++;
            @(negedge clk);
            if (l) break;
        end
        r_ready = 1'b0;
        $display("rd id=%0d A=%h len=%0d burst=%0d beats=%0d data0=%h resp0=%0d",
                 id, a, len, burst, rbeats, rdata[0], rresp[0]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h041,  32'h0123_4567, 32'h0,          2'b00};
        vecs[1]  = '{1'b0, 32'h041,  32'h0,         32'h0123_4567,  2'b00};
        vecs[2]  = '{1'b0, 32'h003,  32'h0,         32'h1,          2'b00};
        vecs[3]  = '{1'b0, 32'h103,  32'h0,         32'h0,          2'b00};
        vecs[4]  = '{1'b1, 32'h000,  32'hFFFF_FFFF, 32'h0,          2'b00};
        vecs[5]  = '{1'b0, 32'h000,  32'h0,         32'h3,          2'b00};
        vecs[6]  = '{1'b1, 32'h081,  32'h1234_5678, 32'h0,          2'b00};
        vecs[7]  = '{1'b0, 32'h081,  32'h0,         32'h678,        2'b00};
        vecs[8]  = '{1'b0, 32'hF01,  32'h0,         32'h0000_2202,  2'b00};
        vecs[9]  = '{1'b1, 32'hF01,  32'h1,         32'h0,          2'b10};
        vecs[10] = '{1'b1, 32'h003,  32'h1,         32'h0,          2'b10};
        vecs[11] = '{1'b0, 32'hF00,  32'h0,         32'hFFFF_FFFF,  2'b10};
        vecs[12] = '{1'b1, 32'h2F0,  32'hDEAD_BEEF, 32'h0,          2'b10};
        vecs[13] = '{1'b0, 32'h044,  32'h0,         32'hFFFF_FFFF,  2'b10};
        vecs[14] = '{1'b0, 32'h1041, 32'h0,         32'hFFFF_FFFF,  2'b10};
        vecs[15] = '{1'b0, 32'h002,  32'h0,         32'hFFFF_FFFF,  2'b10};
        vecs[16] = '{1'b1, 32'h0C4,  32'h5,         32'h0,          2'b10};
        vecs[17] = '{1'b0, 32'h140,  32'h0,         32'h0,          2'b00};

        repeat (3) @(negedge clk);
        check("rst_waddr_ready", 32'(wa_ready), 32'd1);
        check("rst_wdata_ready", 32'(w_ready), 32'd0);
        check("rst_bvalid", 32'(b_valid), 32'd0);
        check("rst_raddr_ready", 32'(ra_ready), 32'd1);
        check("rst_rvalid", 32'(r_valid), 32'd0);
        check("rst_rdata", r_data, 32'd0);
        check("rst_commit", 32'(commit_o), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr) begin
                wdata[0] = vecs[i].d;
                wr_burst(4'd1, vecs[i].a, 8'd0, 2'b01, resp, bid);
                check($sformatf("vec%0d_wresp", i), 32'(resp), 32'(vecs[i].resp));
            end else begin
                rd_burst(4'd2, vecs[i].a, 8'd0, 2'b01);
                check($sformatf("vec%0d_rbeats", i), 32'(rbeats), 32'd1);
                check($sformatf("vec%0d_rdata", i), rdata[0], vecs[i].exp);
                check($sformatf("vec%0d_rresp", i), 32'(rresp[0]), 32'(vecs[i].resp));
            end
        end
        check("iso_freq01", freq_at(0, 1), 32'd0);
        check("iso_phase01", phase_at(0, 1), 32'd0);
        check("iso_wave", 32'(wave_sel_o), 32'd0);

        // Commit ch0 only; bits above CHANNEL_NUM and a clear bit1 must not touch ch1
        wdata[0] = 32'hFFFF_FFFD;
        wr_burst(4'd3, 32'hF00, 8'd0, 2'b01, resp, bid);
        check("commit_resp", 32'(resp), 32'd0);
        check("commit_pulse", 32'(beat_commit[0]), 32'h1);
        check("commit_pulse_end", 32'(commit_o), 32'd0);
        check("commit_freq01", freq_at(0, 1), 32'h0123_4567);
        check("commit_phase01", phase_at(0, 1), 32'h678);
        check("commit_wave", 32'(wave_sel_o), 32'h3);
        rd_burst(4'd2, 32'h003, 8'd0, 2'b01);
        check("commit_status0", rdata[0], 32'd0);

        wdata[0] = 32'h800;
        wr_burst(4'd1, 32'h080, 8'd0, 2'b01, resp, bid);
        wr_burst(4'd1, 32'h180, 8'd0, 2'b01, resp, bid);
        wdata[0] = 32'h3;
        wr_burst(4'd1, 32'hF00, 8'd0, 2'b01, resp, bid);
        check("align_pulse", 32'(beat_commit[0]), 32'h3);
        check("align_phase0", phase_at(0, 0), 32'h800);
        check("align_phase1", phase_at(1, 0), 32'h800);

        for (int i = 0; i < 4; i++) wdata[i] = 32'h1111_1111 * (i + 1);
        wr_burst(4'd5, 32'h040, 8'd3, 2'b01, resp, bid);
        check("incr_resp", 32'(resp), 32'd0);
        check("incr_bid", 32'(bid), 32'd5);
        rd_burst(4'd6, 32'h040, 8'd3, 2'b01);
        check("incr_rbeats", 32'(rbeats), 32'd4);
        check("incr_rid", 32'(rid), 32'd6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_rdata%0d", i), rdata[i], 32'h1111_1111 * (i + 1));
            check($sformatf("incr_rlast%0d", i), 32'(rlast[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        wdata[0] = 32'hAAAA_AAAA; wdata[1] = 32'hBBBB_BBBB;
        wr_burst(4'd2, 32'h140, 8'd1, 2'b10, resp, bid);
        check("wrap_resp", 32'(resp), 32'h2);
        rd_burst(4'd2, 32'h140, 8'd0, 2'b01);
        check("wrap_nochange", rdata[0], 32'd0);
        rd_burst(4'd4, 32'h002, 8'd1, 2'b01);
        check("rderr_beats", 32'(rbeats), 32'd2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rderr_data%0d", i), rdata[i], 32'hFFFF_FFFF);
            check($sformatf("rderr_resp%0d", i), 32'(rresp[i]), 32'h2);
            check($sformatf("rderr_last%0d", i), 32'(rlast[i]), (i == 1) ? 32'd1 : 32'd0);
        end
        wdata[0] = 32'hABC; wdata[1] = 32'h123;
        wr_burst(4'd3, 32'h083, 8'd1, 2'b01, resp, bid);
        check("sticky_resp", 32'(resp), 32'h2);
        rd_burst(4'd2, 32'h083, 8'd0, 2'b01);
        check("sticky_first_beat", rdata[0], 32'hABC);

        wdata[0] = 32'h1;
        wr_burst(4'd1, 32'h101, 8'd0, 2'b01, resp, bid);
        check("wren_out", 32'(dds_wr_enable_o), 32'h2);
        for (int i = 0; i < 4; i++) wdata[i] = 32'hC0DE_0000 + i;
        wr_burst(4'd7, 32'h102, 8'd3, 2'b00, resp, bid);
        check("wave_resp", 32'(resp), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wave_strobe%0d", i), 32'(beat_strobe[i]), 32'h2);
            check($sformatf("wave_data%0d", i), beat_wdata[i], 32'hC0DE_0000 + i);
        end
        wdata[0] = 32'h0;
        wr_burst(4'd1, 32'h101, 8'd0, 2'b01, resp, bid);
        for (int i = 0; i < 4; i++) wdata[i] = 32'hC0DE_0000 + i;
        wr_burst(4'd7, 32'h102, 8'd3, 2'b00, resp, bid);
        for (int i = 0; i < 4; i++)
            check($sformatf("wave_off_strobe%0d", i), 32'(beat_strobe[i]), 32'd0);

        // Abort an 8-beat burst with reset during its second beat
        @(negedge clk);
        wa_id = 4'd9; wa_addr = OFF + 32'h040; wa_len = 8'd7; wa_burst = 2'b01; wa_valid = 1'b1;
        @(negedge clk);
        wa_valid = 1'b0;
        w_data = 32'h5555_5555; w_valid = 1'b1;
        @(negedge clk);
        w_data = 32'h6666_6666;
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_waddr_ready", 32'(wa_ready), 32'd1);
        check("rst_mid_wdata_ready", 32'(w_ready), 32'd0);
        check("rst_mid_bvalid", 32'(b_valid), 32'd0);
        check("rst_mid_freq01", freq_at(0, 1), 32'd0);
        check("rst_mid_phase00", phase_at(0, 0), 32'd0);
        check("rst_mid_wave", 32'(wave_sel_o), 32'd0);
        check("rst_mid_strobe", 32'(dds_wr_valid_o), 32'd0);
        w_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_rel_waddr_ready", 32'(wa_ready), 32'd1);
        rd_burst(4'd2, 32'h040, 8'd0, 2'b01);
        check("rst_rel_freq_shadow", rdata[0], 32'd0);
        wdata[0] = 32'h7777_7777; wdata[1] = 32'h8888_8888;
        wr_burst(4'd4, 32'h040, 8'd1, 2'b01, resp, bid);
        check("rst_new_resp", 32'(resp), 32'd0);
        check("rst_new_bid", 32'(bid), 32'd4);
        rd_burst(4'd2, 32'h041, 8'd0, 2'b01);
        check("rst_new_readback", rdata[0], 32'h8888_8888);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
